// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Purpose  : Bundle of the fetch-to-decode inputs and the decode-to-ALU
//            outputs of the RV32I decode stage.
// Ports    : master - fetch/control side (drives pc_i, instr_i, clk_en_i,
//                     stall_i, flush_i; observes every decode output)
//            slave  - decode stage side (the reverse)
// Revision : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
  parameter int NUM_CLASSES = 11
);
  // fetch / control inputs to decode
  logic [31:0]            pc_i;
  logic [31:0]            instr_i;
  logic                   clk_en_i;
  logic                   stall_i;
  logic                   flush_i;
  // combinational regfile read addresses
  logic [4:0]             rs1_rd_addr_o;
  logic [4:0]             rs2_rd_addr_o;
  // registered decoded bundle
  logic [31:0]            pc_o;
  logic [4:0]             rs1_o;
  logic [4:0]             rs2_o;
  logic [4:0]             rd_o;
  logic [31:0]            imm_o;
  logic [2:0]             funct3_o;
  logic                   funct7_5_o;
  logic [NUM_CLASSES-1:0] class_o;
  logic                   illegal_o;
  logic                   ecall_o;
  logic                   ebreak_o;
  logic                   mret_o;
  logic                   hazard_stall_o;
  logic                   clk_en_o;

  modport master (
    output pc_i, instr_i, clk_en_i, stall_i, flush_i,
    input  rs1_rd_addr_o, rs2_rd_addr_o, pc_o, rs1_o, rs2_o, rd_o, imm_o,
           funct3_o, funct7_5_o, class_o, illegal_o, ecall_o, ebreak_o,
           mret_o, hazard_stall_o, clk_en_o
  );

  modport slave (
    input  pc_i, instr_i, clk_en_i, stall_i, flush_i,
    output rs1_rd_addr_o, rs2_rd_addr_o, pc_o, rs1_o, rs2_o, rd_o, imm_o,
           funct3_o, funct7_5_o, class_o, illegal_o, ecall_o, ebreak_o,
           mret_o, hazard_stall_o, clk_en_o
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : RV32I decode stage. Decodes the fetched instruction
//            combinationally, registers the decoded bundle for the ALU stage,
//            drives regfile read addresses one cycle ahead so synchronous
//            regfile data lines up with the bundle, and requests a one-cycle
//            stall on a load-use hazard.
// Ports    : clk   - clock
//            rstn  - asynchronous active-low reset
//            bus   - decode_stage_if.slave (fetch inputs, decoded outputs)
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter bit ENABLE_HAZARD = 1'b1,
  parameter int NUM_CLASSES   = 11     // class bit order is fixed; keep at 11
) (
  input  wire logic     clk,
  input  wire logic     rstn,
  decode_stage_if.slave bus
);

  // opcode[6:2] values (opcode[1:0] must be 2'b11)
  localparam logic [4:0] c_OPC_LUI      = 5'b01101;
  localparam logic [4:0] c_OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] c_OPC_JAL      = 5'b11011;
  localparam logic [4:0] c_OPC_JALR     = 5'b11001;
  localparam logic [4:0] c_OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] c_OPC_LOAD     = 5'b00000;
  localparam logic [4:0] c_OPC_STORE    = 5'b01000;
  localparam logic [4:0] c_OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] c_OPC_OP       = 5'b01100;
  localparam logic [4:0] c_OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] c_OPC_SYSTEM   = 5'b11100;

  localparam logic [31:0] c_ECALL  = 32'h0000_0073;
  localparam logic [31:0] c_EBREAK = 32'h0010_0073;
  localparam logic [31:0] c_MRET   = 32'h3020_0073;

  localparam int c_CLS_LOAD = 5;

  // ---------------------------------------------------------------- decode
  logic [31:0]            w_instr;
  logic [4:0]             w_opc;
  logic [2:0]             w_f3;
  logic [6:0]             w_f7;
  logic [31:0]            w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [NUM_CLASSES-1:0] w_class;
  logic [31:0]            w_imm;
  logic                   w_illegal, w_ecall, w_ebreak, w_mret;
  logic                   w_rd_zero, w_uses_rs1, w_uses_rs2;
  logic [4:0]             w_rd;
  logic                   w_hazard;
  logic                   w_update;

  assign w_instr = bus.instr_i;
  assign w_opc   = w_instr[6:2];
  assign w_f3    = w_instr[14:12];
  assign w_f7    = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                    w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                    w_instr[20], w_instr[30:21], 1'b0};

  // Illegal encodings leave w_class all-zero and raise no rs usage, so they
  // can never trigger a hazard.
  always_comb begin
    w_class    = '0;
    w_imm      = '0;
    w_illegal  = 1'b0;
    w_ecall    = 1'b0;
    w_ebreak   = 1'b0;
    w_mret     = 1'b0;
    w_rd_zero  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    if (w_instr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opc)
        c_OPC_LUI:   begin w_class[0] = 1'b1; w_imm = w_imm_u; end
        c_OPC_AUIPC: begin w_class[1] = 1'b1; w_imm = w_imm_u; end
        c_OPC_JAL:   begin w_class[2] = 1'b1; w_imm = w_imm_j; end
        c_OPC_JALR: begin
          if (w_f3 != 3'd0) begin
            w_illegal = 1'b1;
          end else begin
            w_class[3] = 1'b1; w_imm = w_imm_i; w_uses_rs1 = 1'b1;
          end
        end
        c_OPC_BRANCH: begin
          w_class[4] = 1'b1; w_imm = w_imm_b; w_rd_zero = 1'b1;
          w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
        end
        c_OPC_LOAD: begin
          w_class[5] = 1'b1; w_imm = w_imm_i; w_uses_rs1 = 1'b1;
        end
        c_OPC_STORE: begin
          w_class[6] = 1'b1; w_imm = w_imm_s; w_rd_zero = 1'b1;
          w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
        end
        c_OPC_OP_IMM: begin
          w_class[7] = 1'b1; w_imm = w_imm_i; w_uses_rs1 = 1'b1;
        end
        c_OPC_OP: begin
          // funct7 0x20 only selects SUB (f3=0) and SRA (f3=5)
          if ((w_f7 == 7'h00) ||
              ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)))) begin
            w_class[8] = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
          end else begin
            w_illegal = 1'b1;
          end
        end
        c_OPC_MISC_MEM: begin
          w_class[9] = 1'b1; w_imm = w_imm_i; w_rd_zero = 1'b1;
        end
        c_OPC_SYSTEM: begin
          if (w_f3 == 3'd0) begin
            w_rd_zero = 1'b1;
            w_ecall   = (w_instr == c_ECALL);
            w_ebreak  = (w_instr == c_EBREAK);
            w_mret    = (w_instr == c_MRET);
            if (w_ecall || w_ebreak || w_mret) begin
              w_class[10] = 1'b1; w_imm = w_imm_i;
            end else begin
              w_illegal = 1'b1;
            end
          end else begin
            // CSR access reads rs1 (or a zimm that is harmless to compare)
            w_class[10] = 1'b1; w_imm = w_imm_i; w_uses_rs1 = 1'b1;
          end
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  assign w_rd = w_rd_zero ? 5'd0 : w_instr[11:7];

  // ---------------------------------------------------------------- hazard
  logic [NUM_CLASSES-1:0] r_class;
  logic [4:0]             r_rd;
  logic                   r_clk_en;

  generate
    if (ENABLE_HAZARD) begin : g_hazard_on
      // Load in the ALU slot whose rd feeds the instruction now in decode.
      // Once the bubble is inserted r_clk_en drops, so this clears itself
      // after exactly one cycle.
      assign w_hazard = r_clk_en & r_class[c_CLS_LOAD] & (r_rd != 5'd0) &
                        bus.clk_en_i & ~bus.stall_i & ~bus.flush_i &
                        ((w_uses_rs1 & (w_instr[19:15] == r_rd)) |
                         (w_uses_rs2 & (w_instr[24:20] == r_rd)));
    end else begin : g_hazard_off
      assign w_hazard = 1'b0;
    end
  endgenerate

  assign w_update = bus.clk_en_i & ~bus.stall_i & ~w_hazard;

  // ------------------------------------------------------------- registers
  logic [31:0] r_pc;
  logic [4:0]  r_rs1, r_rs2;
  logic [31:0] r_imm;
  logic [2:0]  r_f3;
  logic        r_f7_5;
  logic        r_illegal, r_ecall, r_ebreak, r_mret;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_f3      <= '0;
      r_f7_5    <= 1'b0;
      r_class   <= '0;
      r_illegal <= 1'b0;
      r_ecall   <= 1'b0;
      r_ebreak  <= 1'b0;
      r_mret    <= 1'b0;
      r_clk_en  <= 1'b0;
    end else begin
      if (w_update) begin
        r_pc      <= bus.pc_i;
        r_rs1     <= w_instr[19:15];
        r_rs2     <= w_instr[24:20];
        r_rd      <= w_rd;
        r_imm     <= w_imm;
        r_f3      <= w_f3;
        r_f7_5    <= w_instr[30];
        r_class   <= w_class;
        r_illegal <= w_illegal;
        r_ecall   <= w_ecall;
        r_ebreak  <= w_ebreak;
        r_mret    <= w_mret;
      end
      // A flush arriving during a stall waits for the stall to drop.
      if (!bus.stall_i) begin
        if (bus.flush_i) begin
          r_clk_en <= 1'b0;
        end else if (w_hazard) begin
          r_clk_en <= 1'b0;
        end else begin
          r_clk_en <= bus.clk_en_i;
        end
      end
    end
  end

  // --------------------------------------------------------------- outputs
  assign bus.rs1_rd_addr_o  = w_instr[19:15];
  assign bus.rs2_rd_addr_o  = w_instr[24:20];
  assign bus.pc_o           = r_pc;
  assign bus.rs1_o          = r_rs1;
  assign bus.rs2_o          = r_rs2;
  assign bus.rd_o           = r_rd;
  assign bus.imm_o          = r_imm;
  assign bus.funct3_o       = r_f3;
  assign bus.funct7_5_o     = r_f7_5;
  assign bus.class_o        = r_class;
  assign bus.illegal_o      = r_illegal;
  assign bus.ecall_o        = r_ecall;
  assign bus.ebreak_o       = r_ebreak;
  assign bus.mret_o         = r_mret;
  assign bus.hazard_stall_o = w_hazard;
  assign bus.clk_en_o       = r_clk_en;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Self-checking bench for decode_stage: a table of directed
//            instruction vectors with hand-computed decode results, plus
//            hand-written sequences for load-use, stall/flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic clk;
  logic rstn;

  decode_stage_if #(.NUM_CLASSES(11)) bus ();

  decode_stage #(
    .ENABLE_HAZARD (1'b1),
    .NUM_CLASSES   (11)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [10:0] cls;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f75;
    logic        ill;
    logic [2:0]  sys;   // {ecall, ebreak, mret}
  } vec_t;

  vec_t tbl [18];

  initial begin
    //            instr          cls     imm           rd    rs1   rs2   f3    f75   ill   sys
    tbl[0]  = '{32'h00500093, 11'h080, 32'h00000005, 5'd1, 5'd0, 5'd5, 3'd0, 1'b0, 1'b0, 3'b000}; // addi x1,x0,5
    tbl[1]  = '{32'hFE000EE3, 11'h010, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 3'b000}; // beq -4
    tbl[2]  = '{32'h0080006F, 11'h004, 32'h00000008, 5'd0, 5'd0, 5'd8, 3'd0, 1'b0, 1'b0, 3'b000}; // jal x0,8
    tbl[3]  = '{32'h12345137, 11'h001, 32'h12345000, 5'd2, 5'd8, 5'd3, 3'd5, 1'b0, 1'b0, 3'b000}; // lui
    tbl[4]  = '{32'h00001197, 11'h002, 32'h00001000, 5'd3, 5'd0, 5'd0, 3'd1, 1'b0, 1'b0, 3'b000}; // auipc
    tbl[5]  = '{32'h0020A423, 11'h040, 32'h00000008, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 1'b0, 3'b000}; // sw
    tbl[6]  = '{32'h0000A283, 11'h020, 32'h00000000, 5'd5, 5'd1, 5'd0, 3'd2, 1'b0, 1'b0, 3'b000}; // lw x5
    tbl[7]  = '{32'h00000073, 11'h400, 32'h00000000, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 3'b100}; // ecall
    tbl[8]  = '{32'h00100073, 11'h400, 32'h00000001, 5'd0, 5'd0, 5'd1, 3'd0, 1'b0, 1'b0, 3'b010}; // ebreak
    tbl[9]  = '{32'h30200073, 11'h400, 32'h00000302, 5'd0, 5'd0, 5'd2, 3'd0, 1'b0, 1'b0, 3'b001}; // mret
    tbl[10] = '{32'h0FF0000F, 11'h200, 32'h000000FF, 5'd0, 5'd0, 5'd31, 3'd0, 1'b0, 1'b0, 3'b000}; // fence
    tbl[11] = '{32'h00000000, 11'h000, 32'h00000000, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b1, 3'b000}; // bad [1:0]
    tbl[12] = '{32'h0000000B, 11'h000, 32'h00000000, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b1, 3'b000}; // custom opc
    tbl[13] = '{32'h40001033, 11'h000, 32'h00000000, 5'd0, 5'd0, 5'd0, 3'd1, 1'b1, 1'b1, 3'b000}; // f7=20,f3=1
    tbl[14] = '{32'h00001067, 11'h000, 32'h00000000, 5'd0, 5'd0, 5'd0, 3'd1, 1'b0, 1'b1, 3'b000}; // jalr f3=1
    tbl[15] = '{32'h02000033, 11'h000, 32'h00000000, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b1, 3'b000}; // f7=01
    tbl[16] = '{32'h402081B3, 11'h100, 32'h00000000, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 1'b0, 3'b000}; // sub x3
    tbl[17] = '{32'hFFF280E7, 11'h008, 32'hFFFFFFFF, 5'd1, 5'd5, 5'd31, 3'd0, 1'b1, 1'b0, 3'b000}; // jalr -1

    // ------------------------------------------------------------ reset
    rstn         = 1'b0;
    bus.pc_i     = 32'h0;
    bus.instr_i  = 32'h00500093;
    bus.clk_en_i = 1'b1;
    bus.stall_i  = 1'b0;
    bus.flush_i  = 1'b0;
    repeat (3) tick();
    chk("rst.clk_en",  {31'b0, bus.clk_en_o},       32'h0);
    chk("rst.class",   {21'b0, bus.class_o},        32'h0);
    chk("rst.imm",     bus.imm_o,                   32'h0);
    chk("rst.pc",      bus.pc_o,                    32'h0);
    chk("rst.rd",      {27'b0, bus.rd_o},           32'h0);
    chk("rst.illegal", {31'b0, bus.illegal_o},      32'h0);
    chk("rst.hazard",  {31'b0, bus.hazard_stall_o}, 32'h0);
    rstn = 1'b1;

    // ------------------------------------------------------------ table
    for (int i = 0; i < 18; i++) begin
      bus.instr_i  = tbl[i].instr;
      bus.pc_i     = 32'h100 + 32'(4 * i);
      bus.clk_en_i = 1'b1;
      #1;
      chk($sformatf("v%0d.rs1_rd_addr", i), {27'b0, bus.rs1_rd_addr_o}, {27'b0, tbl[i].rs1});
      chk($sformatf("v%0d.rs2_rd_addr", i), {27'b0, bus.rs2_rd_addr_o}, {27'b0, tbl[i].rs2});
      tick();
      chk($sformatf("v%0d.clk_en", i),  {31'b0, bus.clk_en_o},  32'h1);
      chk($sformatf("v%0d.pc", i),      bus.pc_o,               32'h100 + 32'(4 * i));
      chk($sformatf("v%0d.class", i),   {21'b0, bus.class_o},   {21'b0, tbl[i].cls});
      chk($sformatf("v%0d.illegal", i), {31'b0, bus.illegal_o}, {31'b0, tbl[i].ill});
      if (!tbl[i].ill)
        chk($sformatf("v%0d.imm", i), bus.imm_o, tbl[i].imm);
      chk($sformatf("v%0d.rd", i),      {27'b0, bus.rd_o},      {27'b0, tbl[i].rd});
      chk($sformatf("v%0d.rs1", i),     {27'b0, bus.rs1_o},     {27'b0, tbl[i].rs1});
      chk($sformatf("v%0d.rs2", i),     {27'b0, bus.rs2_o},     {27'b0, tbl[i].rs2});
      chk($sformatf("v%0d.funct3", i),  {29'b0, bus.funct3_o},  {29'b0, tbl[i].f3});
      chk($sformatf("v%0d.funct7_5", i), {31'b0, bus.funct7_5_o}, {31'b0, tbl[i].f75});
      chk($sformatf("v%0d.sys", i), {29'b0, bus.ecall_o, bus.ebreak_o, bus.mret_o},
          {29'b0, tbl[i].sys});
      chk($sformatf("v%0d.hazard", i),  {31'b0, bus.hazard_stall_o}, 32'h0);
    end

    // ------------------------------------------------- load-use hazard
    bus.instr_i = 32'h0000A283;   // lw x5,0(x1)
    bus.pc_i    = 32'h300;
    tick();
    bus.instr_i = 32'h00028333;   // add x6,x5,x0
    bus.pc_i    = 32'h304;
    bus.stall_i = 1'b1;
    #1;
    chk("lu.haz_stall_sup", {31'b0, bus.hazard_stall_o}, 32'h0);
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b1;
    #1;
    chk("lu.haz_flush_sup", {31'b0, bus.hazard_stall_o}, 32'h0);
    bus.flush_i = 1'b0;
    #1;
    chk("lu.hazard",        {31'b0, bus.hazard_stall_o}, 32'h1);
    tick();
    chk("lu.bubble",        {31'b0, bus.clk_en_o},       32'h0);
    chk("lu.haz_cleared",   {31'b0, bus.hazard_stall_o}, 32'h0);
    chk("lu.rd_held",       {27'b0, bus.rd_o},           32'd5);
    chk("lu.pc_held",       bus.pc_o,                    32'h300);
    tick();
    chk("lu.add_valid",     {31'b0, bus.clk_en_o},       32'h1);
    chk("lu.add_rs1",       {27'b0, bus.rs1_o},          32'd5);
    chk("lu.add_rd",        {27'b0, bus.rd_o},           32'd6);
    chk("lu.add_class",     {21'b0, bus.class_o},        32'h100);
    chk("lu.add_pc",        bus.pc_o,                    32'h304);

    // -------------------------------------------- load to x0: no hazard
    bus.instr_i = 32'h0000A003;   // lw x0,0(x1)
    bus.pc_i    = 32'h400;
    tick();
    bus.instr_i = 32'h00028333;
    bus.pc_i    = 32'h404;
    #1;
    chk("lx0.no_hazard", {31'b0, bus.hazard_stall_o}, 32'h0);
    tick();
    chk("lx0.add_valid", {31'b0, bus.clk_en_o},       32'h1);
    chk("lx0.add_pc",    bus.pc_o,                    32'h404);

    // ---------------------------------------------------- stall / flush
    bus.instr_i = 32'h00500093;
    bus.pc_i    = 32'h200;
    tick();
    bus.stall_i = 1'b1;
    bus.instr_i = 32'h12345137;
    bus.pc_i    = 32'h204;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("st%0d.pc", k),     bus.pc_o,              32'h200);
      chk($sformatf("st%0d.imm", k),    bus.imm_o,             32'h5);
      chk($sformatf("st%0d.class", k),  {21'b0, bus.class_o},  32'h080);
      chk($sformatf("st%0d.clk_en", k), {31'b0, bus.clk_en_o}, 32'h1);
    end
    bus.flush_i = 1'b1;
    tick();
    chk("st.flush_held",  {31'b0, bus.clk_en_o}, 32'h1);
    bus.stall_i = 1'b0;
    tick();
    chk("st.flush_taken", {31'b0, bus.clk_en_o}, 32'h0);
    bus.flush_i = 1'b0;

    // ------------------------------------------------- async reset
    bus.instr_i = 32'h00500093;
    bus.pc_i    = 32'h500;
    tick();
    chk("ar.valid_before", {31'b0, bus.clk_en_o}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("ar.clk_en", {31'b0, bus.clk_en_o}, 32'h0);
    chk("ar.pc",     bus.pc_o,              32'h0);
    tick();
    rstn = 1'b1;
    tick();
    chk("ar.recover", {31'b0, bus.clk_en_o}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
